// File: rtl/adder_delay_model.sv
// Clocked adder with cycle-accurate propagation delay: inertial mode swallows short pulses
// and counts them, transport mode delivers every result through a LAT-deep pipeline.
module adder_delay_model #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LAT   = 3,
   parameter int unsigned MODE  = 0,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             pending,
   output logic             drop,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int unsigned RW = WIDTH + 1;

   logic [RW-1:0] r;
   logic [RW-1:0] res_q;

   assign r   = RW'(a) + RW'(b) + RW'(ci);
   assign sum = res_q[WIDTH-1:0];
   assign co  = res_q[WIDTH];

   if (MODE == 0) begin : g_inertial
      localparam int unsigned   CW     = (LAT > 1) ? $clog2(LAT) : 1;
      localparam int unsigned   IW     = 2 * WIDTH + 1;
      localparam logic [CW-1:0] CdInit = CW'(LAT - 1);

      logic [IW-1:0]    in_vec;
      logic [IW-1:0]    prev_q;
      logic [RW-1:0]    target_q;
      logic [CW-1:0]    cd_q;
      logic             pend_q;
      logic             drop_q;
      logic [CNT_W-1:0] cnt_q;
      logic             changed;

      assign in_vec  = {a, b, ci};
      assign changed = (in_vec != prev_q);

      always_ff @(posedge clk) begin
         if (rst) begin
            prev_q   <= '0;
            target_q <= '0;
            cd_q     <= '0;
            pend_q   <= 1'b0;
            drop_q   <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
         end else begin
            prev_q <= in_vec;
            drop_q <= 1'b0;
            if (changed) begin
               // A change while the event is still counting down cancels it; a change on the
               // commit edge lets the old event land first.
               if (pend_q && (cd_q != '0)) begin
                  drop_q <= 1'b1;
                  if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
               end else if (pend_q) begin
                  res_q <= target_q;
               end
               target_q <= r;
               cd_q     <= CdInit;
               pend_q   <= 1'b1;
            end else if (pend_q) begin
               if (cd_q == '0) begin
                  res_q  <= target_q;
                  pend_q <= 1'b0;
               end else begin
                  cd_q <= cd_q - CW'(1);
               end
            end
         end
      end

      assign pending  = pend_q;
      assign drop     = drop_q;
      assign drop_cnt = cnt_q;
   end else begin : g_transport
      logic [RW-1:0] pipe_q [LAT];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
            res_q <= '0;
         end else begin
            pipe_q[0] <= r;
            for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
            res_q <= pipe_q[LAT-1];
         end
      end

      assign pending  = 1'b0;
      assign drop     = 1'b0;
      assign drop_cnt = '0;
   end

endmodule

// File: doc/adder_delay_model.md
Name: adder_delay_model

Overview:
Clocked, parametrised successor to the continuous-assignment delayed adder. Computes {co,sum} = a + b + ci and models propagation delay in clock cycles. Two delay semantics are selectable: inertial, where the output updates only if the inputs stay stable for LAT cycles, and transport, where every input change propagates after LAT cycles. In inertial mode, cancelled (swallowed) output events are counted. Used in delay-modelling experiments and as a reference model for timing-semantics comparisons.

Parameters:
WIDTH, 4, operand and sum width in bits (>=1)
LAT, 3, delay in clock cycles from input sample to output update (>=1)
MODE, 0, 0 = inertial, 1 = transport
CNT_W, 8, width of saturating dropped-event counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
a  input  WIDTH  operand A, sampled every rising edge
b  input  WIDTH  operand B, sampled every rising edge
ci  input  1  carry in, sampled every rising edge
sum  output  WIDTH  registered sum, low WIDTH bits of a+b+ci
co  output  1  registered carry out, bit WIDTH of a+b+ci
pending  output  1  inertial: an output event is scheduled; transport: always 0
drop  output  1  one-cycle pulse when a scheduled inertial event is cancelled; transport: always 0
drop_cnt  output  CNT_W  saturating count of drop pulses; transport: always 0

Behaviour:
- Arithmetic: r = a + b + ci, computed at WIDTH+1 bits with no truncation before split. co = r[WIDTH], sum = r[WIDTH-1:0].
- Reset (rst high at an edge): sum=0, co=0, pending=0, drop=0, drop_cnt=0. Internal state also clears: prev_in={a,b,ci} history=0, countdown=0, target=0, transport pipeline all 0. rst has priority over all other activity. No event scheduled before reset commits after it.
- Change detection (inertial): at each edge, compare the sampled {a,b,ci} with prev_in, the value sampled at the previous edge. prev_in updates every non-reset edge. After reset prev_in=0, so nonzero inputs at the first edge count as a change.
- Inertial, per edge, in priority order:
  1. Change and pending=1 and countdown!=0: drop=1, drop_cnt increments (saturates at all-ones). target<=r, countdown<=LAT-1, pending stays 1.
  2. Change and pending=1 and countdown==0: commit {co,sum}<=old target, then target<=r, countdown<=LAT-1, pending stays 1. No drop.
  3. Change and pending=0: target<=r, countdown<=LAT-1, pending<=1.
  4. No change, pending=1, countdown==0: {co,sum}<=target, pending<=0.
  5. No change, pending=1, countdown!=0: countdown decrements.
  6. Otherwise: hold.
- Inertial latency: an input change sampled at edge k that is stable through edge k+LAT-1 appears at edge k+LAT. An input change that re-triggers with an identical result value still cancels and reschedules the event, and is counted as a drop.
- Transport: a LAT-deep pipeline of r. The r sampled at edge k appears on {co,sum} at edge k+LAT. Every value is delivered, none are dropped. For LAT cycles after reset the output is 0.
- drop is a registered pulse, high exactly in the cycle after the triggering edge.
- Countdown is sized to clog2(LAT) bits, minimum 1. LAT=1 gives a one-edge delay in both modes.

Test Plan:
(All scenarios WIDTH=4, LAT=3, MODE=0 unless noted.)
1. Reset: hold rst high for 2 edges with a=5, b=2, ci=1 -> co=0, sum=0, pending=0, drop_cnt=0 throughout.
2. Single change: a=3, b=4, ci=1 sampled first at edge 10 and held -> pending=1 after edges 10-12; sum=8, co=0 after edge 13; pending=0 after edge 13.
3. Glitch train: b=1, ci=1; a=1, 2, 15 at edges 10, 11, 12, then held -> drop pulses after edges 11 and 12; drop_cnt=2; co=1, sum=1 (17) after edge 15; no intermediate output values.
4. Same train with MODE=1 -> {co,sum}=3 after edge 13, 4 after edge 14, 17 (co=1, sum=1) after edge 15; drop=0, drop_cnt=0.
5. Boundary: change at edge 10 (a=3, b=4, ci=1), next change at edge 13 (a=9, b=9, ci=0) -> sum=8 commits at edge 13; co=1, sum=2 commits at edge 16; drop never pulses.
6. Reset mid-flight and saturation: pending=1, rst at edge 12 -> outputs stay 0, pending=0, no later commit. With CNT_W=2, 5 consecutive drops -> drop_cnt=3 and holds at 3.
